char_render_ctrl: RTL and testbench
===================================

CHAR_RENDER_CTRL -- requirements
Module: char_render_ctrl

Interface
REQ-001 Parameter COLS, default 80, text columns per screen.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter BLINK_FRAMES, default 30, frames per cursor blink half-period.
REQ-004 clk  input  1  pixel clock; single clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 h_cnt  input  10  current pixel column from timing generator.
REQ-007 v_cnt  input  10  current pixel line from timing generator.
REQ-008 de_in, hsync_in, vsync_in  input  1 each  display-enable and syncs, aligned with h_cnt/v_cnt.
REQ-009 text_addr  output  12  text-buffer cell index, row*COLS+col.
REQ-010 text_data  input  8  character code; valid exactly 1 cycle after text_addr (registered RAM).
REQ-011 char_address  output  12  font ROM address, {code[7:0], line[3:0]}.
REQ-012 data_rom  input  8  font byte; combinational from char_address, same cycle.
REQ-013 cursor_col  input  7  cursor column; cursor_row  input  5  cursor row; cursor_en  input  1  cursor enable.
REQ-014 pix_out  output  1  rendered pixel, 1 = foreground.
REQ-015 de_out, hsync_out, vsync_out  output  1 each  inputs delayed to align with pix_out.

Function
REQ-016 Pipeline SHALL be 3 stages; pix_out/de_out/hsync_out/vsync_out SHALL correspond to h_cnt/v_cnt sampled 3 cycles earlier.
REQ-017 Stage 0 (combinational): col = h_cnt[9:3], row = v_cnt[8:4], text_addr = row*COLS+col, 12-bit truncating multiply-add.
REQ-018 Stage 1 register: x_bit = h_cnt[2:0], line = v_cnt[3:0], cell-is-cursor flag, de/syncs.
REQ-019 char_address SHALL be driven from text_data and stage-1 line; stage-2 register SHALL capture data_rom plus stage-1 side-band.
REQ-020 Stage 3: pix_out = font_byte[7 - x_bit] XOR cursor_hit, gated by de; pix_out SHALL be 0 whenever delayed de is 0.
REQ-021 cursor_hit = cursor_en AND blink_phase AND cell-is-cursor AND line >= 14.
REQ-022 Cells with col >= COLS or row >= ROWS SHALL force stage-2 font byte to 0 and text_addr to 0.
REQ-023 Frame counter SHALL increment on vsync_in rising edge (edge detected with one flop); at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-024 Blink FSM states: SHOW (blink_phase=1), HIDE (blink_phase=0); transition only on counter wrap; cursor_en=0 SHALL NOT stop the counter.
REQ-025 Changes to cursor_col/cursor_row SHALL take effect at the next stage-1 sample, no frame alignment.
REQ-026 Simultaneous vsync edge and counter wrap: one increment, wrap and toggle in same cycle; no double count.

Reset
REQ-027 While rst_n=0: all pipeline registers, pix_out, de_out, hsync_out, vsync_out SHALL be 0; frame counter 0; state SHOW.
REQ-028 Reset deassertion mid-line SHALL produce de_out=0 for the first 3 cycles, then normal pipelined output; no partial stale pixels.
REQ-029 text_addr and char_address are combinational and not required to reset.

Verification
REQ-030 Code 0x41 at cell 0, ROM line 0 = 0x18, h_cnt 0..7, v_cnt 0, de_in=1 -> pix_out 0,0,0,1,1,0,0,0 on cycles 3..10.
REQ-031 h_cnt=17, v_cnt=35 -> text_addr=2*80+2=162; char_address={code,4'h3} next cycle.
REQ-032 cursor_en=1, cursor at (5,2), SHOW, line 14 of glyph 0x00 -> pix_out=1 for 8 pixels; line 13 -> 0; after 30 vsync edges (HIDE) line 14 -> 0.
REQ-033 de_in low for h_cnt >= 640 with nonzero font byte -> pix_out=0, de_out low exactly 3 cycles after de_in falls.
REQ-034 Assert rst_n=0 mid-line, release -> outputs 0 throughout reset and 3 cycles after, frame counter restarts at 0, state SHOW.
REQ-035 hsync_in/vsync_in pulses -> hsync_out/vsync_out identical width, delayed 3 cycles.

Source files
------------

// File: rtl/char_render_ctrl_if.sv
// Signal bundle between the character renderer and its timing source, text RAM,
// font ROM, cursor registers and video sink.
interface char_render_ctrl_if;
  logic [9:0]  h_cnt, v_cnt;
  logic        de_in, hsync_in, vsync_in;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [11:0] char_address;
  logic [7:0]  data_rom;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic        pix_out, de_out, hsync_out, vsync_out;

  modport master (
    output h_cnt, v_cnt, de_in, hsync_in, vsync_in, text_data, data_rom,
           cursor_col, cursor_row, cursor_en,
    input  text_addr, char_address, pix_out, de_out, hsync_out, vsync_out
  );

  modport slave (
    input  h_cnt, v_cnt, de_in, hsync_in, vsync_in, text_data, data_rom,
           cursor_col, cursor_row, cursor_en,
    output text_addr, char_address, pix_out, de_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/char_render_ctrl.sv
// Text-mode character renderer: cell lookup -> font fetch -> pixel select,
// three registered stages, with a frame-counted blinking underline cursor.
module char_render_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  char_render_ctrl_if.slave bus
);
  localparam int STAGES = 3;
  localparam int CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {SHOW, HIDE} blink_e;
  typedef struct packed { logic de; logic hs; logic vs; } sync_t;
  typedef struct packed { logic [2:0] x; logic [3:0] line; logic cur; logic oob; } s1_t;
  typedef struct packed { logic [7:0] font; logic [2:0] x; logic [3:0] line; logic cur; } s2_t;

  logic [6:0]  col;
  logic [4:0]  row;
  logic        oob;
  logic [11:0] lin_addr;
  sync_t                sb_in;
  sync_t [STAGES:1]     sb_d, sb_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic        hit, pix_d, pix_q;
  logic        vs_d, vs_q, vs_rise, wrap;
  logic [CW-1:0] cnt_d, cnt_q;
  blink_e      state_q;
  logic        blink_q;

  // Stage 0: cell coordinates and text-buffer address.
  always_comb begin
    col      = bus.h_cnt[9:3];
    row      = bus.v_cnt[8:4];
    oob      = (int'(col) >= COLS) || (int'(row) >= ROWS);
    lin_addr = 12'(int'(row) * COLS + int'(col));
    sb_in    = '{de: bus.de_in, hs: bus.hsync_in, vs: bus.vsync_in};
    s1_d      = '0;
    s1_d.x    = bus.h_cnt[2:0];
    s1_d.line = bus.v_cnt[3:0];
    s1_d.cur  = (col == bus.cursor_col) && (row == bus.cursor_row);
    s1_d.oob  = oob;
  end

  assign bus.text_addr    = oob ? 12'd0 : lin_addr;
  // RAM returns the code during stage 1, so the ROM lookup happens there.
  assign bus.char_address = {bus.text_data, s1_q.line};

  always_comb begin
    s2_d      = '0;
    s2_d.font = s1_q.oob ? 8'd0 : bus.data_rom;
    s2_d.x    = s1_q.x;
    s2_d.line = s1_q.line;
    s2_d.cur  = s1_q.cur;
    sb_d      = {sb_q[STAGES-1:1], sb_in};
    hit       = bus.cursor_en & blink_q & s2_q.cur & (s2_q.line >= 4'd14);
    pix_d     = sb_q[2].de & (s2_q.font[3'd7 - s2_q.x] ^ hit);
  end

  // Frame counter advances on vsync rising edges regardless of cursor_en.
  always_comb begin
    vs_d    = bus.vsync_in;
    vs_rise = bus.vsync_in & ~vs_q;
    wrap    = vs_rise && (cnt_q == CW'(BLINK_FRAMES - 1));
    cnt_d   = cnt_q;
    if (wrap)         cnt_d = '0;
    else if (vs_rise) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      sb_q  <= '0;
      pix_q <= 1'b0;
      vs_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      sb_q  <= sb_d;
      pix_q <= pix_d;
      vs_q  <= vs_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHOW;
      blink_q <= 1'b1;
    end else if (wrap) begin
      case (state_q)
        SHOW:    begin state_q <= HIDE; blink_q <= 1'b0; end
        default: begin state_q <= SHOW; blink_q <= 1'b1; end
      endcase
    end
  end

  assign bus.pix_out   = pix_q;
  assign bus.de_out    = sb_q[STAGES].de;
  assign bus.hsync_out = sb_q[STAGES].hs;
  assign bus.vsync_out = sb_q[STAGES].vs;
endmodule

// File: tb/tb_char_render_ctrl.sv
// Bench for char_render_ctrl: directed tables and sequences plus a randomized run,
// all compared each cycle against a cell/glyph/blink reference model.
module tb_char_render_ctrl;
  localparam int NC = 80, NR = 30, BF = 30;

  logic clk, rst_n;
  char_render_ctrl_if bus();

  char_render_ctrl #(.COLS(NC), .ROWS(NR), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] text_mem [4096];
  logic [7:0] font_rom [4096];

  always @(posedge clk) bus.text_data <= text_mem[bus.text_addr];
  assign bus.data_rom = font_rom[bus.char_address];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [9:0] h, v;
    logic de, hs, vs, cen;
    logic [6:0] cc;
    logic [4:0] cr;
    bit blink;
  } rec_t;

  rec_t hist [4];
  rec_t mr;
  int   ns, nrise;
  logic pvs;

  function automatic logic [3:0] exp_out(input int j);
    rec_t r, r1, r2;
    int col, row, addr;
    bit oob, px, hit;
    logic [7:0] code, f;
    r  = hist[j % 4];
    r1 = hist[(j + 1) % 4];
    r2 = hist[(j + 2) % 4];
    col  = int'(r.h) / 8;
    row  = (int'(r.v) / 16) % 32;
    oob  = (col >= NC) || (row >= NR);
    addr = (row * NC + col) % 4096;
    code = text_mem[addr];
    f    = oob ? 8'd0 : font_rom[{code, r.v[3:0]}];
    px   = f[7 - (int'(r.h) % 8)];
    hit  = r2.cen && r1.blink && (col == int'(r.cc)) && (row == int'(r.cr)) && ((int'(r.v) % 16) >= 14);
    return {r.de & (px ^ hit), r.de, r.hs, r.vs};
  endfunction

  initial begin
    ns = 0; nrise = 0; pvs = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ns = 0; nrise = 0; pvs = 1'b0;
      end else begin
        mr.h = bus.h_cnt; mr.v = bus.v_cnt;
        mr.de = bus.de_in; mr.hs = bus.hsync_in; mr.vs = bus.vsync_in;
        mr.cen = bus.cursor_en; mr.cc = bus.cursor_col; mr.cr = bus.cursor_row;
        if (bus.vsync_in && !pvs) nrise++;
        pvs = bus.vsync_in;
        mr.blink = ((nrise / BF) % 2) == 0;
        hist[ns % 4] = mr;
        ns++;
        #1;
        if (ns < 3)
          chk("pipe_fill_zero", {bus.pix_out, bus.de_out, bus.hsync_out, bus.vsync_out}, 4'd0);
        else
          chk("pipe_out", {bus.pix_out, bus.de_out, bus.hsync_out, bus.vsync_out}, exp_out(ns - 3));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int h, input int v, input bit de, input bit hs, input bit vs);
    @(negedge clk);
    bus.h_cnt = 10'(h); bus.v_cnt = 10'(v);
    bus.de_in = de; bus.hsync_in = hs; bus.vsync_in = vs;
  endtask

  task automatic vpulses(input int n);
    repeat (n) begin
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0);
    end
  endtask

  // Eight pixels across the cursor cell (col 5, row 2) on a given line.
  task automatic cursor_line(input int v, input bit exp, input string nm);
    for (int i = 0; i < 11; i++) begin
      tick(i < 8 ? 40 + i : 0, v, i < 8, 0, 0);
      if (i >= 3) chk(nm, bus.pix_out, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.pix_out, bus.de_out, bus.hsync_out, bus.vsync_out};
  endfunction

  typedef struct { int h; int v; logic [11:0] addr; } vec_t;
  vec_t tbl [7];

  int  p30  [8]  = '{0, 0, 0, 1, 1, 0, 0, 0};
  int  h33  [12] = '{0, 1, 2, 3, 3, 4, 640, 641, 642, 643, 644, 3};
  bit  de33 [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int  px33 [9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    tbl[0] = '{h: 17,   v: 35,   addr: 12'd162};
    tbl[1] = '{h: 0,    v: 0,    addr: 12'd0};
    tbl[2] = '{h: 639,  v: 479,  addr: 12'd2399};
    tbl[3] = '{h: 640,  v: 0,    addr: 12'd0};
    tbl[4] = '{h: 0,    v: 480,  addr: 12'd0};
    tbl[5] = '{h: 1023, v: 1023, addr: 12'd0};
    tbl[6] = '{h: 8,    v: 512,  addr: 12'd1};

    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'($urandom);
      font_rom[i] = 8'($urandom);
    end
    text_mem[0]     = 8'h41;
    font_rom[12'h410] = 8'h18;
    text_mem[165]   = 8'h00;
    font_rom[12'h00D] = 8'h00;
    font_rom[12'h00E] = 8'h00;

    rst_n = 1'b0;
    bus.h_cnt = '0; bus.v_cnt = '0;
    bus.de_in = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    bus.cursor_col = 7'd5; bus.cursor_row = 5'd2; bus.cursor_en = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick(i * 8, 0, 1, 1, 1);
      chk("in_reset_outs", outs(), 4'd0);
    end
    tick(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // text_addr mapping and out-of-range cells
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].h, tbl[i].v, 1, 0, 0);
      #1 chk("text_addr", bus.text_addr, tbl[i].addr);
    end

    tick(17, 35, 1, 0, 0);
    @(posedge clk);
    #1 chk("char_address", bus.char_address, {text_mem[162], 4'h3});

    // Glyph 0x41 line 0 rendered across cell 0
    for (int i = 0; i < 11; i++) begin
      tick(i, 0, 1, 0, 0);
      if (i >= 3) chk("glyph41_px", bus.pix_out, p30[i - 3]);
    end

    // de gating and de_out delay
    for (int i = 0; i < 12; i++) begin
      tick(h33[i], 0, de33[i], 0, 0);
      if (i >= 3) begin
        chk("gate_de_out", bus.de_out, de33[i - 3]);
        chk("gate_px", bus.pix_out, px33[i - 3]);
      end
    end

    // Cursor underline and blink period
    bus.cursor_en = 1'b1;
    cursor_line(46, 1, "cursor_show_l14");
    cursor_line(45, 0, "cursor_l13");
    vpulses(BF - 1);
    cursor_line(46, 1, "cursor_show_pre_wrap");
    vpulses(1);
    cursor_line(46, 0, "cursor_hide_l14");

    // Sync pulse width and delay
    for (int i = 0; i < 14; i++) begin
      tick(0, 0, 0, (i >= 2 && i < 7), (i >= 4 && i < 8));
      if (i >= 3) begin
        chk("hsync_out", bus.hsync_out, (i - 3 >= 2 && i - 3 < 7));
        chk("vsync_out", bus.vsync_out, (i - 3 >= 4 && i - 3 < 8));
      end
    end

    // Mid-line reset from HIDE with a partly advanced frame counter
    vpulses(2 * BF);
    cursor_line(46, 0, "pre_reset_hide");
    tick(40, 46, 1, 0, 0);
    tick(41, 46, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs(), 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(42 + i, 46, 1, 1, 1);
      chk("rst_hold_outs", outs(), 4'd0);
    end
    tick(40, 46, 1, 0, 0);
    rst_n = 1'b1;
    #1 chk("rst_release_outs", outs(), 4'd0);
    for (int i = 1; i < 8; i++) begin
      tick(40 + i, 46, 1, 0, 0);
      if (i < 3) chk("rst_release_zero", outs(), 4'd0);
      else       chk("rst_release_px", {bus.pix_out, bus.de_out}, 2'b11);
    end
    vpulses(BF - 1);
    cursor_line(46, 1, "post_reset_show");
    vpulses(1);
    cursor_line(46, 0, "post_reset_hide");

    // Randomized run against the model
    begin
      bit vsr = 1'b0;
      int h, v;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 2) == 0) vsr = ~vsr;
        if ($urandom_range(0, 2) == 0) begin
          h = int'(bus.cursor_col) * 8 + int'($urandom_range(0, 7));
          v = int'($urandom_range(0, 1)) * 512 + int'(bus.cursor_row) * 16 + int'($urandom_range(12, 15));
        end else if ($urandom_range(0, 1) == 0) begin
          h = int'($urandom_range(0, 639));
          v = int'($urandom_range(0, 479));
        end else begin
          h = int'($urandom_range(0, 1023));
          v = int'($urandom_range(0, 1023));
        end
        tick(h, v, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, vsr);
        if ($urandom_range(0, 39) == 0) begin
          bus.cursor_col = 7'($urandom_range(0, 90));
          bus.cursor_row = 5'($urandom_range(0, 31));
        end
        if ($urandom_range(0, 29) == 0) bus.cursor_en = ~bus.cursor_en;
      end
    end
    repeat (4) tick(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
